// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared definitions for the Simulink-to-PPC OPB register slave: word indices,
// CTRL bit positions and handshake FSM encoding.
package opb_register_simulink2ppc_pkg;

  localparam logic [1:0] IDX_DATA  = 2'd0;
  localparam logic [1:0] IDX_COUNT = 2'd1;
  localparam logic [1:0] IDX_CTRL  = 2'd2;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_NEW    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } hs_state_e;

endpackage

// File: rtl/opb_register_simulink2ppc_handshake.sv
// OPB slave handshake: address window decode, IDLE/ACK/HOLD FSM and a
// single-cycle transfer acknowledge.
module opb_slave_handshake
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [31:0] addr,
  output logic        ack,
  output logic [1:0]  idx
);

  hs_state_e   state_q, state_d;
  logic [32:0] lo_diff, hi_diff;
  logic        hit;
  logic        unused_bits;

  // Window bounds via borrow bits so a zero base does not fold to a constant compare.
  assign lo_diff     = {1'b0, addr} - {1'b0, C_BASEADDR};
  assign hi_diff     = {1'b0, C_HIGHADDR} - {1'b0, addr};
  assign hit         = select & ~lo_diff[32] & ~hi_diff[32];
  assign idx         = lo_diff[3:2];
  assign unused_bits = ^{lo_diff[31:4], lo_diff[1:0], hi_diff[31:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: if (!select) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign ack = (state_q == ST_ACK);

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB register slave publishing a fabric value (DATA), capture count (COUNT,
// present only with SIMULINK2PPC_CNT_EN) and FREEZE/NEW control bits.
module opb_register_simulink2ppc
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_valid
);

  localparam bit FAMILY_SET = (C_FAMILY != "");

  logic [31:0] data_q, data_d;
  logic        freeze_q, freeze_d;
  logic        new_q, new_d;
  logic [31:0] count_rd, rdata;
  logic [1:0]  idx;
  logic        ack, rd_acc, wr_acc, cap;
  logic        unused_ok;

  opb_slave_handshake #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_hs (
    .clk    (OPB_Clk),
    .rst    (OPB_Rst),
    .select (OPB_select),
    .addr   (OPB_ABus),
    .ack    (ack),
    .idx    (idx)
  );

  assign rd_acc = ack & OPB_RNW;
  assign wr_acc = ack & ~OPB_RNW;
  assign cap    = user_valid & ~freeze_q;

  // OPB is big-endian numbered: OPB_BE[3] and OPB_DBus[31] carry register bits 7:0 / bit 0.
  always_comb begin
    data_d   = data_q;
    freeze_d = freeze_q;
    new_d    = new_q;
    if (rd_acc && idx == IDX_CTRL) new_d = 1'b0;
    if (cap) begin
      data_d = user_data_in;
      new_d  = 1'b1;
    end
    if (wr_acc && idx == IDX_CTRL && OPB_BE[3]) freeze_d = OPB_DBus[31 - CTRL_FREEZE];
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_q   <= '0;
      freeze_q <= 1'b0;
      new_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      freeze_q <= freeze_d;
      new_q    <= new_d;
    end
  end

`ifdef SIMULINK2PPC_CNT_EN
  logic [31:0] count_q, count_d;

  // A clearing write beats a concurrent capture.
  always_comb begin
    count_d = count_q;
    if (wr_acc && idx == IDX_COUNT && (|OPB_BE)) count_d = '0;
    else if (cap)                                count_d = count_q + 32'd1;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_rd = count_q;
`else
  assign count_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_DATA:  rdata = data_q;
      IDX_COUNT: rdata = count_rd;
      IDX_CTRL: begin
        rdata[CTRL_FREEZE] = freeze_q;
        rdata[CTRL_NEW]    = new_q;
      end
      default:   rdata = '0;
    endcase
  end

  // Wired-OR bus: drive zeros unless acknowledging a read.
  assign Sl_DBus    = rd_acc ? rdata : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, OPB_DBus[0:30], OPB_BE[0:2], FAMILY_SET,
                       C_OPB_AWIDTH, C_OPB_DWIDTH};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed plus randomized bench for opb_register_simulink2ppc against a
// behavioural register model.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_00FF;
`ifdef SIMULINK2PPC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = '0;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] user_data_in = '0;
  logic        user_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data, m_count;
  logic        m_freeze, m_new;

  opb_register_simulink2ppc #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_in(user_data_in), .user_valid(user_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return m_data;
      2'd1:    return CNT_EN ? m_count : 32'd0;
      2'd2:    return {30'd0, m_new, m_freeze};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = '0; m_count = '0; m_freeze = 1'b0; m_new = 1'b0;
  endtask

  task automatic model_capture(input logic [31:0] d);
    if (!m_freeze) begin
      m_data  = d;
      m_count = m_count + 32'd1;
      m_new   = 1'b1;
    end
  endtask

  // Effect of one acknowledged access plus an optional capture on the same edge.
  task automatic model_access(input logic rnw, input logic [1:0] idx, input logic [0:3] be,
                              input logic [31:0] wd, input logic cap, input logic [31:0] cd);
    logic frz_write;
    frz_write = !rnw && idx == 2'd2 && be[3];
    if (rnw && idx == 2'd2) m_new = 1'b0;
    if (cap) model_capture(cd);
    if (!rnw && idx == 2'd1 && be != 4'b0000) m_count = '0;
    if (frz_write) m_freeze = wd[0];
  endtask

  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [0:3] be,
                      input logic [31:0] wd, input logic cap, input logic [31:0] cd,
                      output logic [31:0] rd);
    logic [31:0] off, exp;
    off = addr - BASE;
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = wd;
    user_valid = 1'b0;
    #1 chk("ack_before_edge", {31'd0, Sl_xferAck}, 32'd0);
    @(negedge OPB_Clk);
    chk("ack_asserted", {31'd0, Sl_xferAck}, 32'd1);
    exp = rnw ? model_read(off[3:2]) : 32'd0;
    rd = Sl_DBus;
    chk(rnw ? "read_data" : "write_dbus_zero", rd, exp);
    if (cap) begin user_valid = 1'b1; user_data_in = cd; end
    model_access(rnw, off[3:2], be, wd, cap, cd);
    @(negedge OPB_Clk);
    chk("ack_single_cycle", {31'd0, Sl_xferAck}, 32'd0);
    chk("dbus_hold_zero", Sl_DBus, 32'd0);
    OPB_select = 1'b0; user_valid = 1'b0;
    @(negedge OPB_Clk);
  endtask

  task automatic pulse_capture(input logic [31:0] d);
    @(negedge OPB_Clk);
    user_valid = 1'b1; user_data_in = d;
    model_capture(d);
    @(negedge OPB_Clk);
    user_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, cnt_before;
    model_reset();

    // Reset state
    #1 chk("rst_ack", {31'd0, Sl_xferAck}, 32'd0);
    chk("rst_dbus", Sl_DBus, 32'd0);
    chk("rst_misc", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
    repeat (3) @(negedge OPB_Clk);
    OPB_Rst = 1'b0;

    xfer(1'b1, 32'h0, 4'hF, 0, 1'b0, 0, rd); chk("rst_data0", rd, 32'h0);
    xfer(1'b1, 32'h4, 4'hF, 0, 1'b0, 0, rd); chk("rst_count0", rd, 32'h0);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("rst_ctrl0", rd, 32'h0);

    // Capture and NEW clear-on-read
    pulse_capture(32'hDEADBEEF);
    xfer(1'b1, 32'h0, 4'hF, 0, 1'b0, 0, rd); chk("data_deadbeef", rd, 32'hDEADBEEF);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("ctrl_new_set", rd, 32'h2);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("ctrl_new_clr", rd, 32'h0);
    xfer(1'b1, 32'hC, 4'hF, 0, 1'b0, 0, rd); chk("idx3_zero", rd, 32'h0);

    // FREEZE blocks capture
    xfer(1'b1, 32'h4, 4'hF, 0, 1'b0, 0, cnt_before);
    xfer(1'b0, 32'h8, 4'hF, 32'h1, 1'b0, 0, rd);
    pulse_capture(32'h12345678);
    xfer(1'b1, 32'h0, 4'hF, 0, 1'b0, 0, rd); chk("frozen_data", rd, 32'hDEADBEEF);
    xfer(1'b1, 32'h4, 4'hF, 0, 1'b0, 0, rd); chk("frozen_count", rd, cnt_before);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("frozen_ctrl", rd, 32'h1);
    xfer(1'b0, 32'h8, 4'b1110, 32'h0, 1'b0, 0, rd);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("freeze_be_gated", rd, 32'h1);
    xfer(1'b0, 32'h8, 4'b0001, 32'h0, 1'b0, 0, rd);

    // Read of CTRL with concurrent capture keeps NEW
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b1, 32'hA5A5_0001, rd); chk("ctrl_read_cap", rd, 32'h0);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("new_set_wins", rd, 32'h2);

`ifdef SIMULINK2PPC_CNT_EN
    // Counter wrap via backdoor
    @(negedge OPB_Clk);
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge OPB_Clk);
    release dut.count_q;
    m_count = 32'hFFFF_FFFF;
    xfer(1'b1, 32'h4, 4'hF, 0, 1'b0, 0, rd); chk("count_max", rd, 32'hFFFF_FFFF);
    pulse_capture(32'h0BAD_F00D);
    xfer(1'b1, 32'h4, 4'hF, 0, 1'b0, 0, rd); chk("count_wrap", rd, 32'h0);
`endif

    // Clear COUNT concurrent with capture: clear wins, DATA updates
    pulse_capture(32'h1111_2222);
    xfer(1'b0, 32'h4, 4'b0100, 32'h0, 1'b1, 32'hCAFE_F00D, rd);
    xfer(1'b1, 32'h4, 4'hF, 0, 1'b0, 0, rd); chk("count_clr_wins", rd, 32'h0);
    xfer(1'b1, 32'h0, 4'hF, 0, 1'b0, 0, rd); chk("data_on_clr", rd, 32'hCAFE_F00D);

    // Out-of-window address never acks
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_ABus = HIGH + 32'd4; OPB_RNW = 1'b1; OPB_BE = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge OPB_Clk);
      chk("miss_ack", {31'd0, Sl_xferAck}, 32'd0);
      chk("miss_dbus", Sl_DBus, 32'd0);
    end
    OPB_select = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d, c;
      logic        cap;
      logic [0:3]  be;
      a   = BASE + $urandom_range(0, 255);
      d   = $urandom;
      c   = $urandom;
      cap = $urandom_range(0, 1);
      be  = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0:       pulse_capture(c);
        1:       xfer(1'b1, a, 4'hF, 0, cap, c, rd);
        default: xfer(1'b0, a, be, d, cap, c, rd);
      endcase
    end

    // Reset during ACK aborts the transfer
    pulse_capture(32'h7777_8888);
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_ABus = 32'h0; OPB_RNW = 1'b1; OPB_BE = 4'hF;
    @(negedge OPB_Clk);
    chk("pre_rst_ack", {31'd0, Sl_xferAck}, 32'd1);
    OPB_Rst = 1'b1;
    #1 chk("rst_drops_ack", {31'd0, Sl_xferAck}, 32'd0);
    chk("rst_drops_dbus", Sl_DBus, 32'd0);
    model_reset();
    @(negedge OPB_Clk);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    chk("post_rst_idle", {31'd0, Sl_xferAck}, 32'd0);
    xfer(1'b1, 32'h0, 4'hF, 0, 1'b0, 0, rd); chk("post_rst_data", rd, 32'h0);
    xfer(1'b1, 32'h8, 4'hF, 0, 1'b0, 0, rd); chk("post_rst_ctrl", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, meaning first byte address of the register window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h000000FF, meaning last byte address of the register window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, meaning OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32, meaning OPB data width.
REQ-005 SHALL have parameter C_FAMILY, default "virtex5", meaning target family string (informational).
REQ-006 SHALL have one clock and an asynchronous active-high reset, with ports as listed below.
REQ-007 OPB_Clk  in  1  sole clock; all logic rising-edge.
REQ-008 OPB_Rst  in  1  asynchronous active-high reset.
REQ-009 OPB_ABus  in  [0:31]  address; OPB_BE in [0:3] byte enables; OPB_DBus in [0:31] write data.
REQ-010 OPB_RNW  in  1  1=read; OPB_select in 1 transfer request; OPB_seqAddr in 1 (ignored).
REQ-011 Sl_DBus  out  [0:31]  read data; Sl_xferAck out 1; Sl_errAck, Sl_retry, Sl_toutSup out 1 each.
REQ-012 user_data_in  in  [31:0]  fabric value to publish; user_valid in 1 capture strobe.

Function
REQ-013 Hit: OPB_select=1 and C_BASEADDR<=OPB_ABus<=C_HIGHADDR; word index = (OPB_ABus-C_BASEADDR)[3:2].
REQ-014 Map: idx0 DATA (RO), idx1 COUNT (read; write-to-clear), idx2 CTRL (bit0 FREEZE RW, bit1 NEW RO, clear-on-read), idx3 reads 0.
REQ-015 FSM IDLE->ACK on hit; ACK->HOLD unconditionally; HOLD->IDLE when OPB_select=0; IDLE stays on miss.
REQ-016 Sl_xferAck SHALL be 1 only in ACK (exactly one cycle, latency 1 cycle from first hit cycle).
REQ-017 Sl_DBus SHALL be all-zero except in ACK with OPB_RNW=1 (wired-OR bus).
REQ-018 Sl_errAck, Sl_retry, Sl_toutSup SHALL be constant 0.
REQ-019 Bit order: Sl_DBus[i] = register bit (31-i); OPB_DBus likewise; OPB_BE[3] gates bits 7:0.
REQ-020 Capture: user_valid=1 and FREEZE=0 -> DATA<=user_data_in, COUNT<=COUNT+1 (mod 2^32, FFFFFFFF->0), NEW<=1.
REQ-021 user_valid while FREEZE=1 SHALL change nothing.
REQ-022 Read of CTRL in ACK clears NEW; simultaneous capture in same cycle leaves NEW=1 (set wins).
REQ-023 Write to COUNT with any OPB_BE bit set in ACK clears COUNT; simultaneous capture -> COUNT=0 (clear wins); DATA still updates.
REQ-024 Write to CTRL with OPB_BE[3]=1 loads FREEZE from bit0; other bits/registers ignore writes but are acked.
REQ-025 Read data SHALL be the register value at the ACK-cycle clock edge (pre-update).

Reset
REQ-026 OPB_Rst=1 SHALL asynchronously force FSM=IDLE, DATA=0, COUNT=0, FREEZE=0, NEW=0, Sl_xferAck=0, Sl_DBus=0.
REQ-027 Reset mid-transfer SHALL abort without ack; after release the FSM requires a fresh hit.

Configuration
REQ-028 Macro SIMULINK2PPC_CNT_EN defined: COUNT register and clear logic present as above.
REQ-029 Macro undefined: COUNT logic removed, idx1 reads 0, writes to idx1 acked and ignored; all else unchanged.

Structure
REQ-030 Shared package SHALL hold register index constants (DATA/COUNT/CTRL), CTRL bit positions, FSM state encoding.
REQ-031 Sub-module opb_slave_handshake SHALL implement decode, IDLE/ACK/HOLD FSM and xferAck; top holds registers.

Verification
REQ-032 Reset then read idx0/1/2 -> xferAck one cycle each, data 0x00000000.
REQ-033 user_valid with data 0xDEADBEEF, read idx0 -> 0xDEADBEEF; read CTRL -> 0x2, second CTRL read -> 0x0.
REQ-034 Write CTRL=0x1 (BE=1111), pulse user_valid with 0x12345678 -> DATA unchanged, COUNT unchanged.
REQ-035 Force COUNT=0xFFFFFFFF via 2^32-1 captures (or backdoor), one more capture -> COUNT=0; write idx1 concurrent with capture -> COUNT=0.
REQ-036 Address C_HIGHADDR+4 with select held 5 cycles -> no xferAck, Sl_DBus=0; OPB_Rst pulse during ACK -> xferAck drops immediately.
